// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the sys_pll reconfiguration sequencer.
package pll_reconfig_pkg;

  typedef enum logic [2:0] {
    ST_PWD       = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_IDLE      = 3'd3,
    ST_GATE      = 3'd4,
    ST_APPLY     = 3'd5,
    ST_UNGATE    = 3'd6
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_BAD_ARG = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam int GATE_CYCLES = 2;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for the raw PLL lock plus a saturating stable-lock filter.
module pll_lock_sync #(
  parameter int LOCK_STABLE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic pll_lock,
  output logic lock_s,
  output logic lock_stable
);

  localparam int SW = $clog2(LOCK_STABLE + 1);

  logic          meta_q;
  logic          sync_q;
  logic [SW-1:0] stable_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= '0;
    end else begin
      meta_q <= pll_lock;
      sync_q <= meta_q;
      // Any dropout of the synchronised lock restarts the stability window.
      if (clr || !sync_q) begin
        stable_q <= '0;
      end else if (stable_q != SW'(LOCK_STABLE)) begin
        stable_q <= stable_q + SW'(1);
      end
    end
  end

  assign lock_s      = sync_q;
  assign lock_stable = (stable_q == SW'(LOCK_STABLE));

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Sequencer for the sys_pll dynamic-configuration interface: bring-up, gated per-channel updates, relock with retry.
// Optional macro PLL_LOCK_MON_EN adds an idle lock-loss monitor, autonomous relock and the lock_loss_cnt port.
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_CH       = 5,
  parameter int DIV_W        = 10,
  parameter int PHASE_W      = 13,
  parameter int DEF_ODIV     = 100,
  parameter int DEF_DUTY     = 100,
  parameter int DEF_PHASE    = 16,
  parameter int PWD_CYCLES   = 8,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 8,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRY    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_req,
  input  logic [NUM_CH-1:0]         cfg_ch_mask,
  input  logic [DIV_W-1:0]          cfg_odiv,
  input  logic [DIV_W-1:0]          cfg_duty,
  input  logic [PHASE_W-1:0]        cfg_phase,
  output logic                      cfg_ack,
  output logic                      done,
  output logic [1:0]                err,
  output logic                      busy,
  output logic                      locked,
  output logic                      pll_pwd,
  output logic                      pll_rst,
  output logic                      rstodiv,
  output logic [NUM_CH-1:0]         clkout_gate,
  output logic [NUM_CH*DIV_W-1:0]   dyn_odiv,
  output logic [NUM_CH*DIV_W-1:0]   dyn_duty,
  output logic [NUM_CH*PHASE_W-1:0] dyn_phase,
`ifdef PLL_LOCK_MON_EN
  output logic [7:0]                lock_loss_cnt,
`endif
  input  logic                      pll_lock,
  output logic [2:0]                dbg_state,
  output logic                      dbg_lock_s
);

  localparam int CNT_A   = (PWD_CYCLES > RST_CYCLES) ? PWD_CYCLES : RST_CYCLES;
  localparam int CNT_MAX = (LOCK_TIMEOUT > CNT_A) ? LOCK_TIMEOUT : CNT_A;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);

  state_e                      state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [RTY_W-1:0]            retry_q;
  logic                        cfg_seq_q;
  logic                        bad_q;
  logic                        pwd_q, pll_rst_q, busy_q, locked_q, ack_q, done_q;
  logic [1:0]                  err_q;
  logic [NUM_CH-1:0]           gate_q, cap_mask_q;
  logic [DIV_W-1:0]            cap_odiv_q, cap_duty_q;
  logic [PHASE_W-1:0]          cap_phase_q;
  logic [NUM_CH*DIV_W-1:0]     odiv_q, duty_q;
  logic [NUM_CH*PHASE_W-1:0]   phase_q;
  logic                        lock_s, lock_stable, args_bad, mon_trip;

  pll_lock_sync #(.LOCK_STABLE(LOCK_STABLE)) u_lock_sync (
    .clk         (clk),
    .rst         (rst),
    .clr         (state_q != ST_WAIT_LOCK),
    .pll_lock    (pll_lock),
    .lock_s      (lock_s),
    .lock_stable (lock_stable)
  );

  // One spare bit so 2*odiv cannot wrap against duty.
  assign args_bad = (cfg_ch_mask == '0) || (cfg_odiv == '0) || (cfg_duty == '0) ||
                    ({1'b0, cfg_duty} >= {cfg_odiv, 1'b0});

`ifdef PLL_LOCK_MON_EN
  logic [1:0] loss_run_q;
  logic [7:0] loss_cnt_q;

  assign mon_trip = (state_q == ST_IDLE) && locked_q && !lock_s && (loss_run_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_run_q <= 2'd0;
      loss_cnt_q <= 8'd0;
    end else begin
      if ((state_q == ST_IDLE) && locked_q && !lock_s && !mon_trip) loss_run_q <= loss_run_q + 2'd1;
      else loss_run_q <= 2'd0;
      if (mon_trip && (loss_cnt_q != 8'hFF)) loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign mon_trip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PWD;
      cnt_q       <= '0;
      retry_q     <= '0;
      cfg_seq_q   <= 1'b0;
      bad_q       <= 1'b0;
      pwd_q       <= 1'b1;
      pll_rst_q   <= 1'b0;
      busy_q      <= 1'b1;
      locked_q    <= 1'b0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_OK;
      gate_q      <= '1;
      cap_mask_q  <= '0;
      cap_odiv_q  <= '0;
      cap_duty_q  <= '0;
      cap_phase_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        odiv_q[c*DIV_W +: DIV_W]     <= DIV_W'(DEF_ODIV);
        duty_q[c*DIV_W +: DIV_W]     <= DIV_W'(DEF_DUTY);
        phase_q[c*PHASE_W +: PHASE_W] <= PHASE_W'(DEF_PHASE);
      end
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_PWD: begin
          if (cnt_q == CNT_W'(PWD_CYCLES - 1)) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            pwd_q     <= 1'b0;
            pll_rst_q <= 1'b1;
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
        ST_RESET: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
        ST_WAIT_LOCK: begin
          // Lock confirmation takes priority over a coincident timeout.
          if (lock_stable) begin
            state_q  <= ST_UNGATE;
            gate_q   <= '0;
            locked_q <= 1'b1;
            retry_q  <= '0;
            if (cfg_seq_q) begin
              done_q <= 1'b1;
              err_q  <= ERR_OK;
            end
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            cnt_q <= '0;
            if (int'(retry_q) + 1 < MAX_RETRY) begin
              retry_q   <= retry_q + RTY_W'(1);
              state_q   <= ST_RESET;
              pll_rst_q <= 1'b1;
            end else begin
              retry_q  <= '0;
              state_q  <= ST_IDLE;
              busy_q   <= 1'b0;
              locked_q <= 1'b0;
              if (cfg_seq_q) begin
                done_q <= 1'b1;
                err_q  <= ERR_TIMEOUT;
              end
            end
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
        ST_UNGATE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        ST_IDLE: begin
          if (mon_trip) begin
            state_q   <= ST_RESET;
            busy_q    <= 1'b1;
            locked_q  <= 1'b0;
            gate_q    <= '1;
            pll_rst_q <= 1'b1;
            cnt_q     <= '0;
            retry_q   <= '0;
            cfg_seq_q <= 1'b0;
          end else if (bad_q) begin
            bad_q  <= 1'b0;
            done_q <= 1'b1;
            err_q  <= ERR_BAD_ARG;
          end else if (cfg_req && !ack_q) begin
            ack_q       <= 1'b1;
            cap_mask_q  <= cfg_ch_mask;
            cap_odiv_q  <= cfg_odiv;
            cap_duty_q  <= cfg_duty;
            cap_phase_q <= cfg_phase;
            if (args_bad) begin
              bad_q <= 1'b1;
            end else begin
              state_q   <= ST_GATE;
              busy_q    <= 1'b1;
              cnt_q     <= '0;
              gate_q    <= gate_q | cfg_ch_mask;
              locked_q  <= 1'b0;
              cfg_seq_q <= 1'b1;
            end
          end
        end
        ST_GATE: begin
          if (cnt_q == CNT_W'(GATE_CYCLES - 1)) begin
            state_q <= ST_APPLY;
            cnt_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
              if (cap_mask_q[c]) begin
                odiv_q[c*DIV_W +: DIV_W]      <= cap_odiv_q;
                duty_q[c*DIV_W +: DIV_W]      <= cap_duty_q;
                phase_q[c*PHASE_W +: PHASE_W] <= cap_phase_q;
              end
            end
          end else cnt_q <= cnt_q + CNT_W'(1);
        end
        ST_APPLY: begin
          state_q   <= ST_RESET;
          cnt_q     <= '0;
          pll_rst_q <= 1'b1;
        end
        default: begin
          state_q <= ST_PWD;
          cnt_q   <= '0;
          pwd_q   <= 1'b1;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ack     = ack_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign locked      = locked_q;
  assign pll_pwd     = pwd_q;
  assign pll_rst     = pll_rst_q;
  assign rstodiv     = pll_rst_q;
  assign clkout_gate = gate_q;
  assign dyn_odiv    = odiv_q;
  assign dyn_duty    = duty_q;
  assign dyn_phase   = phase_q;
  assign dbg_state   = state_q;
  assign dbg_lock_s  = lock_s;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: bring-up, table and random reconfig requests, lock glitch, mid-sequence reset, timeout.
module tb_pll_reconfig_ctrl;

  localparam int NUM_CH = 5;
  localparam int DIV_W = 10;
  localparam int PHASE_W = 13;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, rst_to = 1'b1;
  logic cfg_req = 1'b0, cfg_req_to = 1'b0;
  logic [NUM_CH-1:0] cfg_ch_mask = '0;
  logic [DIV_W-1:0] cfg_odiv = '0, cfg_duty = '0;
  logic [PHASE_W-1:0] cfg_phase = '0;

  logic cfg_ack, done, busy, locked, pll_pwd, pll_rst, rstodiv, pll_lock, dbg_lock_s;
  logic [1:0] err;
  logic [2:0] dbg_state;
  logic [NUM_CH-1:0] clkout_gate;
  logic [NUM_CH*DIV_W-1:0] dyn_odiv, dyn_duty;
  logic [NUM_CH*PHASE_W-1:0] dyn_phase;

  logic ack_to, done_to, busy_to, locked_to, pwd_to, prst_to, rstodiv_to, lock_s_to;
  logic pll_lock_to = 1'b0;
  logic [1:0] err_to;
  logic [2:0] state_to;
  logic [NUM_CH-1:0] gate_to;
  logic [NUM_CH*DIV_W-1:0] odiv_to, duty_to;
  logic [NUM_CH*PHASE_W-1:0] phase_to;
`ifdef PLL_LOCK_MON_EN
  logic [7:0] loss_cnt, loss_cnt_to;
`endif

  pll_reconfig_ctrl u_dut (
    .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_ch_mask(cfg_ch_mask), .cfg_odiv(cfg_odiv),
    .cfg_duty(cfg_duty), .cfg_phase(cfg_phase), .cfg_ack(cfg_ack), .done(done), .err(err),
    .busy(busy), .locked(locked), .pll_pwd(pll_pwd), .pll_rst(pll_rst), .rstodiv(rstodiv),
    .clkout_gate(clkout_gate), .dyn_odiv(dyn_odiv), .dyn_duty(dyn_duty), .dyn_phase(dyn_phase),
`ifdef PLL_LOCK_MON_EN
    .lock_loss_cnt(loss_cnt),
`endif
    .pll_lock(pll_lock), .dbg_state(dbg_state), .dbg_lock_s(dbg_lock_s)
  );

  pll_reconfig_ctrl #(.LOCK_TIMEOUT(50)) u_to (
    .clk(clk), .rst(rst_to), .cfg_req(cfg_req_to), .cfg_ch_mask(cfg_ch_mask), .cfg_odiv(cfg_odiv),
    .cfg_duty(cfg_duty), .cfg_phase(cfg_phase), .cfg_ack(ack_to), .done(done_to), .err(err_to),
    .busy(busy_to), .locked(locked_to), .pll_pwd(pwd_to), .pll_rst(prst_to), .rstodiv(rstodiv_to),
    .clkout_gate(gate_to), .dyn_odiv(odiv_to), .dyn_duty(duty_to), .dyn_phase(phase_to),
`ifdef PLL_LOCK_MON_EN
    .lock_loss_cnt(loss_cnt_to),
`endif
    .pll_lock(pll_lock_to), .dbg_state(state_to), .dbg_lock_s(lock_s_to)
  );

  // PLL model: locks 100 cycles after reset/power-down release unless the test drives lock by hand
  logic lock_auto = 1'b1, lock_manual = 1'b0, auto_lock = 1'b0;
  int since = 0;
  always @(posedge clk) begin
    if (pll_rst === 1'b1 || pll_pwd === 1'b1) since <= 0;
    else if (since < 1000) since <= since + 1;
    auto_lock <= (since >= 100) && (pll_rst === 1'b0) && (pll_pwd === 1'b0);
  end
  assign pll_lock = lock_auto ? auto_lock : lock_manual;

  int done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // scoreboard
  int n_vec = 0, n_fail = 0;
  logic [1:0] exp_q[$];
  int m_odiv[NUM_CH], m_duty[NUM_CH], m_phase[NUM_CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] model_err(input int mask, input int odiv, input int duty);
    if (mask == 0 || odiv == 0 || duty == 0 || duty >= 2 * odiv) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_odiv[c] = 100; m_duty[c] = 100; m_phase[c] = 16;
    end
  endtask

  task automatic model_apply(input logic [4:0] mask, input int odiv, input int duty, input int phase);
    for (int c = 0; c < NUM_CH; c++)
      if (mask[c]) begin m_odiv[c] = odiv; m_duty[c] = duty; m_phase[c] = phase; end
  endtask

  task automatic check_dyn(input string tag);
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("%s odiv[%0d]", tag, c), 32'(dyn_odiv[c*DIV_W +: DIV_W]), m_odiv[c]);
      check($sformatf("%s duty[%0d]", tag, c), 32'(dyn_duty[c*DIV_W +: DIV_W]), m_duty[c]);
      check($sformatf("%s phase[%0d]", tag, c), 32'(dyn_phase[c*PHASE_W +: PHASE_W]), m_phase[c]);
    end
  endtask

  // driver tasks
  task automatic bring_up(input string tag);
    int n, r, d0;
    d0 = done_cnt;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    check({tag, " rst pll_pwd"}, pll_pwd, 1);
    check({tag, " rst pll_rst"}, pll_rst, 0);
    check({tag, " rst rstodiv"}, rstodiv, 0);
    check({tag, " rst gate"}, clkout_gate, 5'h1f);
    check({tag, " rst busy"}, busy, 1);
    check({tag, " rst locked"}, locked, 0);
    check({tag, " rst ack"}, cfg_ack, 0);
    check({tag, " rst done"}, done, 0);
    check({tag, " rst err"}, err, 0);
    check_dyn({tag, " rst"});
    rst = 1'b0;
    n = 0;
    while (pll_pwd && n < 100) begin n++; @(negedge clk); end
    check({tag, " pwd cycles"}, n, 8);
    n = 0; r = 0;
    while (pll_rst && n < 100) begin n++; if (rstodiv) r++; @(negedge clk); end
    check({tag, " pll_rst cycles"}, n, 16);
    check({tag, " rstodiv cycles"}, r, 16);
    n = 0;
    while (!locked && n < 1000) begin n++; @(negedge clk); end
    check({tag, " locked"}, locked, 1);
    check({tag, " gate clear"}, clkout_gate, 0);
    @(negedge clk);
    check({tag, " busy low"}, busy, 0);
    check({tag, " no done"}, done_cnt - d0, 0);
  endtask

  task automatic wait_done(input string tag, input int budget, output int cyc, output int rsts,
                           output logic [4:0] gseen, output int acks);
    logic prev;
    bit got;
    cyc = 0; rsts = 0; acks = 0; gseen = clkout_gate; prev = pll_rst; got = 0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      gseen |= clkout_gate;
      if (pll_rst && !prev) rsts++;
      prev = pll_rst;
      if (cfg_ack) acks++;
      if (done) got = 1;
    end
    check({tag, " done seen"}, got, 1);
    if (exp_q.size() > 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      if (got) check({tag, " err"}, err, e);
    end
  endtask

  task automatic issue(input logic [4:0] mask, input int odiv, input int duty, input int phase,
                       output int lat);
    cfg_ch_mask = mask; cfg_odiv = DIV_W'(odiv); cfg_duty = DIV_W'(duty); cfg_phase = PHASE_W'(phase);
    cfg_req = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!cfg_ack && lat < 50);
    cfg_req = 1'b0;
  endtask

  task automatic run_cfg(input string tag, input logic [4:0] mask, input int odiv, input int duty,
                         input int phase, input logic [1:0] e);
    int lat, cyc, rsts, acks;
    logic [4:0] gseen;
    exp_q.push_back(e);
    issue(mask, odiv, duty, phase, lat);
    check({tag, " ack latency"}, lat, 1);
    wait_done(tag, 3000, cyc, rsts, gseen, acks);
    if (e == 2'd1) check({tag, " bad done latency"}, cyc, 1);
    check({tag, " pll_rst pulses"}, rsts, (e == 2'd0) ? 1 : 0);
    check({tag, " gated channels"}, gseen, (e == 2'd0) ? mask : 5'h0);
    check({tag, " extra acks"}, acks, 0);
    if (e == 2'd0) model_apply(mask, odiv, duty, phase);
    @(negedge clk);
    check({tag, " busy after"}, busy, 0);
    check({tag, " locked after"}, locked, 1);
    check({tag, " gate after"}, clkout_gate, 0);
    check_dyn(tag);
  endtask

  task automatic wait_rst_fall(input string tag);
    int n;
    n = 0;
    while (!pll_rst && n < 200) begin n++; @(negedge clk); end
    while (pll_rst && n < 400) begin n++; @(negedge clk); end
    check({tag, " reached WAIT_LOCK"}, pll_rst, 0);
  endtask

  typedef struct {
    logic [4:0] mask;
    int odiv, duty, phase;
    logic [1:0] err;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cyc, rsts, acks, d0, n, k, fall_k;
    logic [4:0] gseen;
    logic prev;

    vecs[0] = '{5'b00010, 200, 200, 16, 2'd0};
    vecs[1] = '{5'b00001, 10, 20, 0, 2'd1};
    vecs[2] = '{5'b00000, 100, 100, 5, 2'd1};
    vecs[3] = '{5'b00100, 0, 10, 5, 2'd1};
    vecs[4] = '{5'b01000, 100, 0, 5, 2'd1};
    vecs[5] = '{5'b10000, 512, 1023, 4095, 2'd0};
    vecs[6] = '{5'b00001, 511, 1022, 7, 2'd1};
    vecs[7] = '{5'b11111, 1023, 1023, 8191, 2'd0};
    vecs[8] = '{5'b00011, 1, 1, 1, 2'd0};
    vecs[9] = '{5'b00110, 1, 2, 2, 2'd1};

    bring_up("bringup");

    for (int i = 0; i < 10; i++) run_cfg($sformatf("vec%0d", i), vecs[i].mask, vecs[i].odiv,
                                         vecs[i].duty, vecs[i].phase, vecs[i].err);

    // lock glitch at stable count 7: locked must wait for 8 clean cycles
    issue(5'b00100, 100, 50, 5, lat);
    lock_auto = 1'b0; lock_manual = 1'b0;
    d0 = done_cnt;
    wait_rst_fall("glitch");
    lock_manual = 1'b1;
    for (k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 7) lock_manual = 1'b0;
      if (k == 8) lock_manual = 1'b1;
      if (k == 11) check("glitch locked@11", locked, 0);
      if (k == 18) check("glitch locked@18", locked, 0);
    end
    check("glitch locked@19", locked, 1);
    check("glitch done@19", done, 1);
    check("glitch err", err, 0);
    model_apply(5'b00100, 100, 50, 5);
    lock_auto = 1'b1;
    @(negedge clk);
    check_dyn("glitch");

    // request held across a busy sequence is serviced once the controller is idle again
    exp_q.push_back(2'd0);
    issue(5'b00001, 120, 60, 3, lat);
    cfg_ch_mask = 5'b00010; cfg_odiv = 10'd80; cfg_duty = 10'd40; cfg_phase = 13'd9;
    cfg_req = 1'b1;
    wait_done("held A", 3000, cyc, rsts, gseen, acks);
    check("held no ack while busy", acks, 0);
    n = 0;
    while (!cfg_ack && n < 10) begin n++; @(negedge clk); end
    check("held ack after idle", cfg_ack, 1);
    check("held ack delay", n, 2);
    cfg_req = 1'b0;
    exp_q.push_back(2'd0);
    wait_done("held B", 3000, cyc, rsts, gseen, acks);
    model_apply(5'b00001, 120, 60, 3);
    model_apply(5'b00010, 80, 40, 9);
    @(negedge clk);
    check_dyn("held");

    // random requests against the arithmetic model
    for (int i = 0; i < 16; i++) begin
      logic [4:0] mask;
      int odiv, duty, phase;
      mask = 5'($urandom_range(0, 31));
      odiv = (i % 4 == 0) ? $urandom_range(0, 3) : $urandom_range(1, 1023);
      duty = (i % 3 == 0) ? 2 * odiv - $urandom_range(0, 1) : $urandom_range(0, 1023);
      if (duty < 0) duty = 0;
      if (duty > 1023) duty = 1023;
      phase = $urandom_range(0, 8191);
      run_cfg($sformatf("rand%0d", i), mask, odiv, duty, phase, model_err(mask, odiv, duty));
    end

    // reset during WAIT_LOCK of a reconfig: drop the request, restart bring-up, no done
    issue(5'b11111, 300, 300, 1000, lat);
    wait_rst_fall("midrst");
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    bring_up("midrst");
    check("midrst no done", done_cnt - d0, 0);

    // timeout instance: never locks, LOCK_TIMEOUT = 50
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_to = 1'b0;
    n = 0; rsts = 0; acks = 0; prev = 1'b0;
    while (busy_to && n < 1000) begin
      @(negedge clk);
      n++;
      if (prst_to && !prev) rsts++;
      prev = prst_to;
      if (done_to) acks++;
    end
    check("to bringup idle", busy_to, 0);
    check("to bringup rst pulses", rsts, 3);
    check("to bringup no done", acks, 0);
    check("to bringup locked", locked_to, 0);
    check("to bringup gates", gate_to, 5'h1f);

    cfg_ch_mask = 5'b00001; cfg_odiv = 10'd50; cfg_duty = 10'd50; cfg_phase = 13'd7;
    cfg_req_to = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ack_to && lat < 50);
    cfg_req_to = 1'b0;
    check("to ack latency", lat, 1);
    n = 0; rsts = 0; prev = 1'b0; fall_k = -1;
    while (!done_to && n < 2000) begin
      @(negedge clk);
      n++;
      if (prst_to && !prev) rsts++;
      if (!prst_to && prev) fall_k = 0;
      else if (fall_k >= 0) fall_k++;
      prev = prst_to;
    end
    check("to done seen", done_to, 1);
    check("to err", err_to, 2);
    check("to rst pulses", rsts, 3);
    check("to wait cycles", fall_k, 50);
    check("to locked", locked_to, 0);
    check("to gates held", gate_to, 5'h1f);
    check("to odiv ch0", 32'(odiv_to[0 +: DIV_W]), 50);
    check("to odiv ch1", 32'(odiv_to[DIV_W +: DIV_W]), 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
